// File: rtl/rv32_fetch_pkg.sv
// Shared types and constants for the RV32I instruction-fetch front end.
package rv32_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetch_state_t;

   // addi x0,x0,0
   localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

endpackage

// File: rtl/rv32_fetch_watchdog.sv
// 8-bit response watchdog: counts WAIT cycles, flags the last permitted one.
module rv32_fetch_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] cnt_q, cnt_d;

   // Clear has priority so a fresh grant always starts the count from zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = 8'd0;
      else if (en_i)
         cnt_d = cnt_q + 8'd1;
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= 8'd0;
      else
         cnt_q <= cnt_d;
   end

   assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/rv32_fetch_unit.sv
// Instruction-fetch front end: one-entry tagged buffer, bus FSM, NOP/stall muxing.
module rv32_fetch_unit #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR      = rv32_fetch_pkg::NOP_INSTR_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_fetch,
   input  logic        flush,
   output logic [31:0] code_fetch,
   output logic        stall,
   output logic        fetch_fault,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        imem_err
);

   import rv32_fetch_pkg::*;

   fetch_state_t state_q, state_d;
   logic        buf_valid_q, buf_valid_d;
   logic [29:0] buf_pc_q, buf_pc_d;
   logic [31:0] buf_instr_q, buf_instr_d;
   logic        drop_q, drop_d;
   logic [31:0] addr_q, addr_d;
   logic        fault_q, fault_d;
   logic        wd_clr, wd_expired;
   logic        hit, misaligned;

   assign misaligned = |pc_fetch[1:0];
   assign hit        = buf_valid_q && (buf_pc_q == pc_fetch[31:2]);

   // Misaligned PCs never stall: the core gets a NOP and a fault next cycle.
   assign stall       = !misaligned && !hit;
   assign code_fetch  = (hit && !misaligned) ? buf_instr_q : NOP_INSTR;
   assign imem_req    = (state_q == REQ);
   assign imem_addr   = addr_q;
   assign fetch_fault = fault_q;

   rv32_fetch_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (wd_clr),
      .en_i      (state_q == WAIT),
      .expired_o (wd_expired)
   );

   // Fetch FSM and buffer update; flush overrides any buffer write this cycle.
   always_comb begin
      state_d     = state_q;
      buf_valid_d = buf_valid_q;
      buf_pc_d    = buf_pc_q;
      buf_instr_d = buf_instr_q;
      drop_d      = drop_q;
      addr_d      = addr_q;
      fault_d     = misaligned;
      wd_clr      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!hit && !misaligned && !flush) begin
               state_d = REQ;
               addr_d  = {pc_fetch[31:2], 2'b00};
               drop_d  = 1'b0;
            end
         end
         REQ: begin
            // Address held stable until the bus accepts it.
            if (imem_gnt) begin
               state_d = WAIT;
               wd_clr  = 1'b1;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               state_d = IDLE;
               if (!flush && !drop_q) begin
                  if (imem_err) begin
                     buf_valid_d = 1'b0;
                     fault_d     = 1'b1;
                  end else begin
                     buf_valid_d = 1'b1;
                     buf_pc_d    = addr_q[31:2];
                     buf_instr_d = imem_rdata;
                  end
               end
            end else if (wd_expired) begin
               // Give up; a late response must not be trusted.
               state_d = IDLE;
               fault_d = 1'b1;
               drop_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (flush) begin
         buf_valid_d = 1'b0;
         if (state_q != IDLE)
            drop_d = 1'b1;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         buf_valid_q <= 1'b0;
         buf_pc_q    <= '0;
         buf_instr_q <= '0;
         drop_q      <= 1'b0;
         addr_q      <= RESET_PC;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         buf_valid_q <= buf_valid_d;
         buf_pc_q    <= buf_pc_d;
         buf_instr_q <= buf_instr_d;
         drop_q      <= drop_d;
         addr_q      <= addr_d;
         fault_q     <= fault_d;
      end
   end

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// Directed, table-driven bench for rv32_fetch_unit (TIMEOUT_CYCLES=8).
module tb_rv32_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc_fetch = '0;
   logic        flush = 1'b0;
   logic [31:0] code_fetch;
   logic        stall, fetch_fault, imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0, imem_rvalid = 1'b0, imem_err = 1'b0;
   logic [31:0] imem_rdata = '0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rv32_fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst_n(rst_n), .pc_fetch(pc_fetch), .flush(flush),
      .code_fetch(code_fetch), .stall(stall), .fetch_fault(fetch_fault),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err)
   );

   typedef struct {
      logic [31:0] pc;
      logic        fl, gnt, rv, er;
      logic [31:0] rd;
      logic        st;
      logic [31:0] cd;
      logic        rq;
      logic [31:0] ad;
      logic        ft;
   } vec_t;

   vec_t vt[$];

   task automatic v(input logic [31:0] pc, input logic fl, gnt, rv, er,
                    input logic [31:0] rd, input logic st, input logic [31:0] cd,
                    input logic rq, input logic [31:0] ad, input logic ft);
      vec_t e;
      e.pc = pc; e.fl = fl; e.gnt = gnt; e.rv = rv; e.er = er; e.rd = rd;
      e.st = st; e.cd = cd; e.rq = rq; e.ad = ad; e.ft = ft;
      vt.push_back(e);
   endtask

   task automatic chk(input string nm, input int idx, input logic [31:0] act, exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0d: got %h want %h", nm, idx, act, exp);
      end
   endtask

   task automatic chk_all(input int idx, input logic st, input logic [31:0] cd,
                          input logic rq, input logic [31:0] ad, input logic ft);
      chk("stall", idx, {31'b0, stall}, {31'b0, st});
      chk("code_fetch", idx, code_fetch, cd);
      chk("imem_req", idx, {31'b0, imem_req}, {31'b0, rq});
      chk("imem_addr", idx, imem_addr, ad);
      chk("fetch_fault", idx, {31'b0, fetch_fault}, {31'b0, ft});
   endtask

   task automatic drive(input logic [31:0] pc, input logic fl, gnt, rv, er,
                        input logic [31:0] rd);
      pc_fetch = pc; flush = fl; imem_gnt = gnt; imem_rvalid = rv;
      imem_err = er; imem_rdata = rd;
   endtask

   initial begin
      // pc        fl g rv er rdata          stall code          req addr   fault
      // reset release, immediate grant, response +1
      v(32'h00, 0,0,0,0, 32'h0,          1, NOP,          0, 32'h00, 0);
      v(32'h00, 0,1,0,0, 32'h0,          1, NOP,          1, 32'h00, 0);
      v(32'h00, 0,0,1,0, 32'h00500093,   1, NOP,          0, 32'h00, 0);
      v(32'h00, 0,0,0,0, 32'h0,          0, 32'h00500093, 0, 32'h00, 0);
      // grant held low 4 cycles at 0x10
      v(32'h10, 0,0,0,0, 32'h0,          1, NOP,          0, 32'h00, 0);
      for (int i = 0; i < 4; i++)
         v(32'h10, 0,0,0,0, 32'h0,       1, NOP,          1, 32'h10, 0);
      v(32'h10, 0,1,0,0, 32'h0,          1, NOP,          1, 32'h10, 0);
      v(32'h10, 0,0,1,0, 32'h11111111,   1, NOP,          0, 32'h10, 0);
      v(32'h10, 0,0,0,0, 32'h0,          0, 32'h11111111, 0, 32'h10, 0);
      // misaligned pc 0x6
      v(32'h06, 0,0,0,0, 32'h0,          0, NOP,          0, 32'h10, 0);
      v(32'h10, 0,0,0,0, 32'h0,          0, 32'h11111111, 0, 32'h10, 1);
      v(32'h10, 0,0,0,0, 32'h0,          0, 32'h11111111, 0, 32'h10, 0);
      // flush + redirect to 0x40 while waiting for 0x20
      v(32'h20, 0,0,0,0, 32'h0,          1, NOP,          0, 32'h10, 0);
      v(32'h20, 0,1,0,0, 32'h0,          1, NOP,          1, 32'h20, 0);
      v(32'h40, 1,0,0,0, 32'h0,          1, NOP,          0, 32'h20, 0);
      v(32'h40, 0,0,1,0, 32'h22222222,   1, NOP,          0, 32'h20, 0);
      v(32'h40, 0,0,0,0, 32'h0,          1, NOP,          0, 32'h20, 0);
      v(32'h40, 0,1,0,0, 32'h0,          1, NOP,          1, 32'h40, 0);
      v(32'h40, 0,0,1,0, 32'h44444444,   1, NOP,          0, 32'h40, 0);
      v(32'h40, 0,0,0,0, 32'h0,          0, 32'h44444444, 0, 32'h40, 0);
      // bus error then retry
      v(32'h50, 0,0,0,0, 32'h0,          1, NOP,          0, 32'h40, 0);
      v(32'h50, 0,1,0,0, 32'h0,          1, NOP,          1, 32'h50, 0);
      v(32'h50, 0,0,1,1, 32'hDEADBEEF,   1, NOP,          0, 32'h50, 0);
      v(32'h50, 0,0,0,0, 32'h0,          1, NOP,          0, 32'h50, 1);
      v(32'h50, 0,1,0,0, 32'h0,          1, NOP,          1, 32'h50, 0);
      v(32'h50, 0,0,1,0, 32'h55555555,   1, NOP,          0, 32'h50, 0);
      v(32'h50, 0,0,0,0, 32'h0,          0, 32'h55555555, 0, 32'h50, 0);
      // timeout after 8 WAIT cycles, late responses ignored
      v(32'h60, 0,0,0,0, 32'h0,          1, NOP,          0, 32'h50, 0);
      v(32'h60, 0,1,0,0, 32'h0,          1, NOP,          1, 32'h60, 0);
      for (int i = 0; i < 8; i++)
         v(32'h60, 0,0,0,0, 32'h0,       1, NOP,          0, 32'h60, 0);
      v(32'h60, 0,0,1,0, 32'hBAD0BAD0,   1, NOP,          0, 32'h60, 1);
      v(32'h60, 0,0,1,0, 32'hBAD0BAD1,   1, NOP,          1, 32'h60, 0);
      v(32'h60, 0,1,0,0, 32'h0,          1, NOP,          1, 32'h60, 0);
      v(32'h60, 0,0,1,0, 32'h66666666,   1, NOP,          0, 32'h60, 0);
      v(32'h60, 0,0,0,0, 32'h0,          0, 32'h66666666, 0, 32'h60, 0);

      // reset state
      #3;
      chk_all(-1, 1'b1, NOP, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vt.size(); i++) begin
         if (i > 0) @(negedge clk);
         drive(vt[i].pc, vt[i].fl, vt[i].gnt, vt[i].rv, vt[i].er, vt[i].rd);
         #2;
         chk_all(i, vt[i].st, vt[i].cd, vt[i].rq, vt[i].ad, vt[i].ft);
      end

      // reset asserted mid-transaction (in WAIT for 0x80)
      @(negedge clk); drive(32'h80, 0,0,0,0, 32'h0);
      @(negedge clk); drive(32'h80, 0,1,0,0, 32'h0);
      @(negedge clk); drive(32'h80, 0,0,0,0, 32'h0);
      #2 rst_n = 1'b0;
      pc_fetch = 32'h60;  // was a hit before reset; buffer must now be empty
      #1;
      chk_all(100, 1'b1, NOP, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(32'h60, 0,0,1,0, 32'hBAD0BAD2);  // stray response in IDLE
      #2;
      chk_all(101, 1'b1, NOP, 1'b0, 32'h0, 1'b0);
      @(negedge clk); drive(32'h60, 0,1,0,0, 32'h0);
      #2;
      chk_all(102, 1'b1, NOP, 1'b1, 32'h60, 1'b0);
      @(negedge clk); drive(32'h60, 0,0,1,0, 32'h77777777);
      @(negedge clk); drive(32'h60, 0,0,0,0, 32'h0);
      #2;
      chk_all(103, 1'b0, 32'h77777777, 1'b0, 32'h60, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rv32_fetch_unit.md
# rv32_fetch_unit

Instruction-fetch front end for the RV32I 5-stage core. It sits between the core's code-memory port (`pc_fetch` / `code_fetch` / `stall`) and a multi-cycle instruction-memory bus with request/grant/response handshakes. A one-entry tagged instruction buffer serves hits with zero latency. On a miss the unit holds the core in stall while a finite-state machine fetches the word, and it substitutes NOPs whenever no valid instruction is available.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: `imem_addr` value held in reset.
- `NOP_INSTR`, default 32'h0000_0013 (`addi x0,x0,0`): word driven on `code_fetch` when not delivering a buffered instruction.
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles spent in WAIT before a fault (range 2..255).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc_fetch`  in  32  address requested by the core this cycle.
- `flush`  in  1  core redirect; invalidates the buffer and any in-flight response.
- `code_fetch`  out  32  instruction for `pc_fetch`; valid when `stall`=0.
- `stall`  out  1  core must hold `pc_fetch` and the IF/ID register.
- `fetch_fault`  out  1  one-cycle pulse on bus error, timeout or misaligned PC.
- `imem_req`  out  1  bus request.
- `imem_addr`  out  32  word address `{pc[31:2],2'b00}`.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response valid.
- `imem_rdata`  in  32  response data.
- `imem_err`  in  1  response error, qualified by `imem_rvalid`.

## Operation
- Buffer state: `buf_valid`, `buf_pc[31:2]`, `buf_instr`.
- Hit when `buf_valid` is set and `buf_pc` equals `pc_fetch[31:2]`:
  - `code_fetch`=`buf_instr`, `stall`=0.
  - Both outputs are combinational.
- Miss: `stall`=1, `code_fetch`=`NOP_INSTR`.
- Misaligned PC (`pc_fetch[1:0]`≠0):
  - No request is issued.
  - `stall`=0 and `code_fetch`=`NOP_INSTR`.
  - `fetch_fault` pulses in the following cycle.
- FSM states are IDLE, REQ and WAIT.
  - IDLE → REQ on a miss with aligned PC and no `flush`. `imem_addr` is registered from `pc_fetch`.
  - REQ: `imem_req`=1 and `imem_addr` stays stable until `imem_gnt`; then → WAIT and the timeout counter clears.
  - WAIT → IDLE on `imem_rvalid`.
    - With `imem_err`=0 and `drop`=0: buffer written with the tag and data, `buf_valid`=1.
    - With `imem_err`=1: `buf_valid`=0 and `fetch_fault` pulses.
    - With `drop`=1: the response is discarded.
  - WAIT timeout: when the counter reaches `TIMEOUT_CYCLES-1` → IDLE, `fetch_fault` pulses, and `drop` is set so the late response is ignored.
- `imem_rvalid` outside WAIT is ignored. A response arriving in the same cycle as the grant is illegal on this bus.
- `flush`:
  - Clears `buf_valid`.
  - In REQ or WAIT it sets `drop`. A request in REQ is not retracted; it completes its handshake.
  - `drop` clears on the next IDLE → REQ transition.
- `flush` in the same cycle as `imem_rvalid`: `flush` wins, the buffer stays invalid and the FSM → IDLE.
- `pc_fetch` changing while in REQ or WAIT: the fetch completes at the old address with the old tag, then the next miss starts a new request.

## Timing
- Reset values: state IDLE, `buf_valid`=0, `drop`=0, counter=0, `imem_req`=0, `imem_addr`=`RESET_PC`, `fetch_fault`=0. Consequently `stall`=1 and `code_fetch`=`NOP_INSTR`.
- Hit latency: 0 cycles.
- Minimum miss penalty is 3 stall cycles:
  - Cycle 0: miss detected in IDLE.
  - Cycle 1: REQ, grant received.
  - Cycle 2: WAIT, response received.
  - Cycle 3: hit, `stall`=0.
- Each cycle of grant delay or response delay adds one stall cycle.
- `fetch_fault` is registered and lasts exactly one cycle per event.
- Reset asserted mid-transaction returns all state to reset values immediately. Responses arriving after reset are ignored, because the FSM is in IDLE.

## Structure
- Shared package `rv32_fetch_pkg`: state enum `fetch_state_t` (IDLE, REQ, WAIT) and the default `NOP_INSTR` constant.
- One sub-module, `rv32_fetch_watchdog`: an 8-bit counter with clear/enable inputs and an `expired` output at `TIMEOUT_CYCLES-1`.
- Buffer, FSM and output muxing live in the top module.

## Test plan
- Reset release with `pc_fetch`=0 and memory returning 32'h00500093 (gnt immediate, rvalid +1) → `stall` high for 3 cycles, then `code_fetch`=32'h00500093 with `stall`=0.
- Hold `imem_gnt` low 4 cycles at pc 0x10 → `imem_addr`=0x10 stable with `imem_req` high throughout; stall lasts 7 cycles.
- `flush` plus `pc_fetch`=0x40 during WAIT for 0x20 → the 0x20 response is discarded, then a new request goes out at 0x40 and delivers its data.
- `imem_rvalid` with `imem_err`=1 → `fetch_fault` pulses for 1 cycle, the buffer stays invalid, and a retry request is issued.
- No response with `TIMEOUT_CYCLES`=8 → `fetch_fault` pulses after 8 WAIT cycles, and a late rvalid is ignored.
- `pc_fetch`=0x6 → no `imem_req`, `stall`=0, `code_fetch`=32'h00000013, and a `fetch_fault` pulse.
